rom_ram_arbiter: RTL and testbench

Arbitrates one shared single-port synchronous memory between the CPU instruction-fetch port (read-only) and the CPU data port (read/write).
Sits between the openmips core and the unified instruction/data memory in the minimal SOPC.
Sequences each memory access through issue, wait and acknowledge phases.
Data port has priority; a streak limit prevents instruction-fetch starvation.

---
 rtl/rom_ram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_rom_ram_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_ram_arbiter.sv
// rom_ram_arbiter: shares one synchronous memory between
// the instruction-fetch port and the data port.
module rom_ram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic [DATA_W-1:0]   i_data_o,
  output logic                i_ack_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic [DATA_W-1:0]   d_data_i,
  output logic [DATA_W-1:0]   d_data_o,
  output logic                d_ack_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [DATA_W-1:0]   mem_data_o,
  input  logic [DATA_W-1:0]   mem_data_i,
  output logic                busy_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int SW    = $clog2(MAX_D_STREAK + 1);

  localparam logic [SW-1:0] STREAK_MAX =
    SW'(MAX_D_STREAK);
  localparam logic [2:0] LAT_LAST =
    3'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        cnt_q, cnt_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              is_i_q, is_i_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_i;

  logic [DATA_W-1:0] i_data_d, d_data_d;
  logic              i_ack_d, d_ack_d;
  logic              mem_ce_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [SEL_W-1:0]  mem_sel_d;
  logic [DATA_W-1:0] mem_data_d;
  logic              busy_d;

  // Next state, latched access and next registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    is_i_d   = is_i_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    grant_i  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req_i || d_req_i) begin
          grant_i = i_req_i &&
            (!d_req_i ||
             streak_q == STREAK_MAX);
          state_d = ISSUE;
          unique case (1'b1)
            grant_i: begin
              is_i_d   = 1'b1;
              we_d     = 1'b0;
              addr_d   = i_addr_i;
              sel_d    = '1;
              wdata_d  = '0;
              streak_d = '0;
            end
            default: begin
              is_i_d  = 1'b0;
              we_d    = d_we_i;
              addr_d  = d_addr_i;
              sel_d   = d_sel_i;
              wdata_d = d_data_i;
              if (!i_req_i)
                streak_d = '0;
              else if (streak_q != STREAK_MAX)
                streak_d = streak_q + 1'b1;
            end
          endcase
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = ACK;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_LAST;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          rdata_d = mem_data_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_ce_d   = (state_d == ISSUE);
    mem_we_d   = mem_ce_d && we_d;
    mem_addr_d = mem_ce_d ? addr_d : '0;
    mem_sel_d  = mem_ce_d ? sel_d : '0;
    mem_data_d = mem_ce_d ? wdata_d : '0;
    i_ack_d    = (state_d == ACK) && is_i_d;
    d_ack_d    = (state_d == ACK) && !is_i_d;
    i_data_d   = i_ack_d ? rdata_d : '0;
    d_data_d   = (d_ack_d && !we_d) ?
                 rdata_d : '0;
    busy_d     = (state_d != IDLE);
  end

  // State, latched access and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      is_i_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      i_data_o   <= '0;
      i_ack_o    <= 1'b0;
      d_data_o   <= '0;
      d_ack_o    <= 1'b0;
      mem_ce_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_sel_o  <= '0;
      mem_data_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      is_i_q     <= is_i_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      i_data_o   <= i_data_d;
      i_ack_o    <= i_ack_d;
      d_data_o   <= d_data_d;
      d_ack_o    <= d_ack_d;
      mem_ce_o   <= mem_ce_d;
      mem_we_o   <= mem_we_d;
      mem_addr_o <= mem_addr_d;
      mem_sel_o  <= mem_sel_d;
      mem_data_o <= mem_data_d;
      busy_o     <= busy_d;
    end
  end

endmodule

// File: tb/tb_rom_ram_arbiter.sv
// tb_rom_ram_arbiter: directed bench, one instance with
// MEM_LAT=1 (a_*) and one with MEM_LAT=3 (b_*).
module tb_rom_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_sel;

  logic [31:0] a_i_data, a_d_data;
  logic        a_i_ack, a_d_ack;
  logic        a_mem_ce, a_mem_we, a_busy;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [31:0] a_mem_rdata;
  logic [3:0]  a_mem_sel;

  logic [31:0] b_i_data, b_d_data;
  logic        b_i_ack, b_d_ack;
  logic        b_mem_ce, b_mem_we, b_busy;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata;
  logic [3:0]  b_mem_sel;

  int total = 0;
  int bad   = 0;

  rom_ram_arbiter #(
    .MEM_LAT(1), .MAX_D_STREAK(4)
  ) u_a (
    .clk(clk), .rst(rst),
    .i_req_i(i_req), .i_addr_i(i_addr),
    .i_data_o(a_i_data), .i_ack_o(a_i_ack),
    .d_req_i(d_req), .d_we_i(d_we),
    .d_addr_i(d_addr), .d_sel_i(d_sel),
    .d_data_i(d_wdata),
    .d_data_o(a_d_data), .d_ack_o(a_d_ack),
    .mem_ce_o(a_mem_ce), .mem_we_o(a_mem_we),
    .mem_addr_o(a_mem_addr),
    .mem_sel_o(a_mem_sel),
    .mem_data_o(a_mem_wdata),
    .mem_data_i(a_mem_rdata),
    .busy_o(a_busy)
  );

  rom_ram_arbiter #(
    .MEM_LAT(3), .MAX_D_STREAK(4)
  ) u_b (
    .clk(clk), .rst(rst),
    .i_req_i(i_req), .i_addr_i(i_addr),
    .i_data_o(b_i_data), .i_ack_o(b_i_ack),
    .d_req_i(d_req), .d_we_i(d_we),
    .d_addr_i(d_addr), .d_sel_i(d_sel),
    .d_data_i(d_wdata),
    .d_data_o(b_d_data), .d_ack_o(b_d_ack),
    .mem_ce_o(b_mem_ce), .mem_we_o(b_mem_we),
    .mem_addr_o(b_mem_addr),
    .mem_sel_o(b_mem_sel),
    .mem_data_o(b_mem_wdata),
    .mem_data_i(b_mem_rdata),
    .busy_o(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word i holds A000_0000|i,
  // except word 4 which holds an instruction.
  function automatic logic [31:0] base(int i);
    return (i == 4) ? 32'h3401_1100 :
           (32'hA000_0000 | 32'(i));
  endfunction

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [7:0]  ra_a, ra_b;
  logic [31:0] mask_a, mask_b;

  assign mask_a = {{8{a_mem_sel[3]}},
                   {8{a_mem_sel[2]}},
                   {8{a_mem_sel[1]}},
                   {8{a_mem_sel[0]}}};
  assign mask_b = {{8{b_mem_sel[3]}},
                   {8{b_mem_sel[2]}},
                   {8{b_mem_sel[1]}},
                   {8{b_mem_sel[0]}}};
  assign a_mem_rdata = mem_a[ra_a];
  assign b_mem_rdata = mem_b[ra_b];

  // Memory model behind instance a.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++)
        mem_a[i] <= base(i);
      ra_a <= '0;
    end else if (a_mem_ce) begin
      if (a_mem_we)
        mem_a[a_mem_addr[9:2]] <=
          (mem_a[a_mem_addr[9:2]] & ~mask_a) |
          (a_mem_wdata & mask_a);
      ra_a <= a_mem_addr[9:2];
    end
  end

  // Memory model behind instance b.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++)
        mem_b[i] <= base(i);
      ra_b <= '0;
    end else if (b_mem_ce) begin
      if (b_mem_we)
        mem_b[b_mem_addr[9:2]] <=
          (mem_b[b_mem_addr[9:2]] & ~mask_b) |
          (b_mem_wdata & mask_b);
      ra_b <= b_mem_addr[9:2];
    end
  end

  // Every cycle: acks never overlap, ce never back-to-back.
  logic a_ce_prev = 1'b0;
  logic b_ce_prev = 1'b0;
  always @(negedge clk) begin
    total++;
    assert (!(a_i_ack && a_d_ack) &&
            !(a_mem_ce && a_ce_prev))
    else begin
      bad++;
      $error("FAIL mon_a ack=%b%b ce=%b%b",
             a_i_ack, a_d_ack, a_ce_prev, a_mem_ce);
    end
    total++;
    assert (!(b_i_ack && b_d_ack) &&
            !(b_mem_ce && b_ce_prev))
    else begin
      bad++;
      $error("FAIL mon_b ack=%b%b ce=%b%b",
             b_i_ack, b_d_ack, b_ce_prev, b_mem_ce);
    end
    a_ce_prev = a_mem_ce;
    b_ce_prev = b_mem_ce;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h",
             tag, obs, exp);
    end
  endtask

  logic [31:0] a_or, b_or;
  assign a_or = a_i_data | a_d_data | a_mem_addr |
                a_mem_wdata | 32'(a_mem_sel) |
                32'({a_i_ack, a_d_ack, a_mem_ce,
                     a_mem_we, a_busy});
  assign b_or = b_i_data | b_d_data | b_mem_addr |
                b_mem_wdata | 32'(b_mem_sel) |
                32'({b_i_ack, b_d_ack, b_mem_ce,
                     b_mem_we, b_busy});

  logic exp_gi [10] =
    '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    int nseq, nce, nack, last_ce;
    rst     = 1'b1;
    i_req   = 1'b1;
    d_req   = 1'b1;
    d_we    = 1'b0;
    i_addr  = 32'h10;
    d_addr  = 32'h200;
    d_sel   = 4'hF;
    d_wdata = 32'h0;

    // Reset held two cycles with both requests high.
    tick();
    chk("rst1_a_zero", 64'(a_or), 64'd0);
    chk("rst1_b_zero", 64'(b_or), 64'd0);
    tick();
    chk("rst2_a_zero", 64'(a_or), 64'd0);
    chk("rst2_b_zero", 64'(b_or), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ce", 64'(a_mem_ce), 64'd1);
    chk("post_rst_dwin", 64'(a_mem_addr),
        64'h200);
    chk("post_rst_b_ce", 64'(b_mem_ce), 64'd1);
    i_req = 1'b0;
    d_req = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;

    // Single instruction read on a.
    i_req  = 1'b1;
    i_addr = 32'h10;
    tick();
    chk("ifetch_ce", 64'(a_mem_ce), 64'd1);
    chk("ifetch_addr", 64'(a_mem_addr), 64'h10);
    chk("ifetch_sel", 64'(a_mem_sel), 64'hF);
    chk("ifetch_we", 64'(a_mem_we), 64'd0);
    tick();
    chk("ifetch_noack", 64'(a_i_ack), 64'd0);
    tick();
    chk("ifetch_ack", 64'(a_i_ack), 64'd1);
    chk("ifetch_data", 64'(a_i_data),
        64'h3401_1100);
    i_req = 1'b0;
    tick();
    chk("ifetch_ack_off", 64'(a_i_ack), 64'd0);
    chk("ifetch_data_off", 64'(a_i_data), 64'd0);
    chk("ifetch_idle", 64'(a_busy), 64'd0);

    // Data write on a, then read back.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_sel   = 4'b0011;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_ce", 64'(a_mem_ce), 64'd1);
    chk("wr_we", 64'(a_mem_we), 64'd1);
    chk("wr_addr", 64'(a_mem_addr), 64'h100);
    chk("wr_sel", 64'(a_mem_sel), 64'h3);
    chk("wr_data", 64'(a_mem_wdata),
        64'hDEAD_BEEF);
    d_wdata = 32'h1234_5678;
    tick();
    chk("wr_ack", 64'(a_d_ack), 64'd1);
    chk("wr_dout", 64'(a_d_data), 64'd0);
    chk("wr_ce_off", 64'(a_mem_ce), 64'd0);
    d_req = 1'b0;
    tick();
    d_req = 1'b1;
    d_we  = 1'b0;
    d_sel = 4'hF;
    tick();
    chk("rd_we", 64'(a_mem_we), 64'd0);
    tick();
    tick();
    chk("rd_ack", 64'(a_d_ack), 64'd1);
    chk("rd_data", 64'(a_d_data),
        64'hA000_BEEF);
    d_req = 1'b0;
    tick();

    // Both ports held: streak limit forces fetches.
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h10;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h200;
    nseq   = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (a_i_ack || a_d_ack) begin
        if (nseq < 10) begin
          chk("grant_order", 64'(a_i_ack),
              64'(exp_gi[nseq]));
          if (a_i_ack)
            chk("grant_idata", 64'(a_i_data),
                64'h3401_1100);
          else
            chk("grant_ddata", 64'(a_d_data),
                64'hA000_0080);
        end
        nseq++;
      end
    end
    chk("grant_count", 64'(nseq), 64'd10);
    i_req = 1'b0;
    d_req = 1'b0;

    // Reset in the middle of WAIT on b.
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h20;
    tick();
    chk("mid_ce", 64'(b_mem_ce), 64'd1);
    chk("mid_addr", 64'(b_mem_addr), 64'h20);
    tick();
    tick();
    chk("mid_busy", 64'(b_busy), 64'd1);
    rst   = 1'b1;
    i_req = 1'b0;
    tick();
    chk("mid_zero", 64'(b_or), 64'd0);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("mid_noack", 64'(b_i_ack), 64'd0);
    end
    i_req  = 1'b1;
    i_addr = 32'h30;
    tick();
    chk("rec_ce", 64'(b_mem_ce), 64'd1);
    tick();
    tick();
    tick();
    chk("rec_noack", 64'(b_i_ack), 64'd0);
    tick();
    chk("rec_ack", 64'(b_i_ack), 64'd1);
    chk("rec_data", 64'(b_i_data),
        64'hA000_000C);
    i_req = 1'b0;
    tick();

    // Back-to-back fetches on b, MEM_LAT=3.
    i_req   = 1'b1;
    i_addr  = 32'h40;
    nce     = 0;
    nack    = 0;
    last_ce = 0;
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (b_mem_ce) begin
        if (nce > 0)
          chk("b2b_gap", 64'(t - last_ce), 64'd6);
        else
          chk("b2b_first", 64'(t), 64'd1);
        last_ce = t;
        nce++;
      end
      if (b_i_ack) begin
        chk("b2b_data", 64'(b_i_data),
            64'(32'hA000_0010 + 32'(nack)));
        nack++;
        i_addr = i_addr + 32'd4;
        if (nack == 3)
          i_req = 1'b0;
      end
    end
    chk("b2b_ce_count", 64'(nce), 64'd3);
    chk("b2b_ack_count", 64'(nack), 64'd3);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
